uart_tx_pacer: RTL and testbench
================================

// Module: uart_tx_pacer
// PURPOSE
//  Byte FIFO plus pacing FSM that sits directly upstream of the UART transmitter.
//  Producers push bytes whenever they like; this block issues one-cycle
//  o_TX_DV/o_TX_Byte strobes to the transmitter, spaced one full frame apart.
//  The spacing is needed because the transmitter has no busy/ready output.
//  Sits between command/report logic and the UART transmitter.
// PARAMETERS
//  CLKS_PER_BIT  217                       clocks per UART bit; must match transmitter
//  DEPTH         16                        FIFO entries; power of two, >=2
//  ADDR_W        4                         log2(DEPTH)
//  GAP_CLKS      10*(CLKS_PER_BIT+1)+2     clocks between successive o_TX_DV strobes (>=2)
// PORTS
//  i_Clock     in   1         system clock, rising edge
//  i_Rst_L     in   1         asynchronous active-low reset
//  i_Wr_DV     in   1         write strobe; byte pushed on this edge if accepted
//  i_Wr_Byte   in   8         byte to push
//  o_Full      out  1         count == DEPTH
//  o_Empty     out  1         count == 0
//  o_Count     out  ADDR_W+1  bytes currently stored, 0..DEPTH
//  o_Overflow  out  1         1-cycle pulse: write rejected
//  o_TX_DV     out  1         1-cycle strobe to transmitter data-valid
//  o_TX_Byte   out  8         byte for transmitter; valid while o_TX_DV=1
//  o_Busy      out  1         1 when FSM != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (i_Rst_L=0, async):
//   - pointers=0, count=0, FSM=IDLE, gap counter=0
//   - o_TX_DV=0, o_TX_Byte=8'h00, o_Overflow=0
//   - o_Empty=1, o_Full=0, o_Busy=0
//   - Mid-operation reset discards all FIFO contents and any pending gap.
//  FIFO: circular, wr_ptr/rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0.
//   - Count is tracked separately in ADDR_W+1 bits.
//   - Write accepted iff i_Wr_DV && (count<DEPTH || pop this cycle).
//   - Push while full in the same cycle as a pop: accepted; count stays DEPTH.
//   - Rejected write: o_Overflow=1 next cycle; data dropped; pointers unchanged.
//   - Push+pop same cycle: count unchanged.
//   - o_Full, o_Empty and o_Count are registered with the count (reflect state after the edge).
//  FSM states: IDLE, ISSUE, WAIT.
//   - IDLE: if !o_Empty -> ISSUE.
//   - ISSUE (one cycle):
//     - pop head; register o_TX_Byte=head; o_TX_DV=1 on the next cycle only.
//     - load gap counter = GAP_CLKS-2; -> WAIT.
//   - WAIT: decrement the counter.
//     - at 0: -> ISSUE if FIFO non-empty (no bubble), else -> IDLE.
//  Timing:
//   - Write into empty FIFO at edge N: o_Empty=0 after N; ISSUE after N+1;
//     o_TX_DV high in the cycle after edge N+2 (latency 3 clocks).
//   - Back-to-back bytes: o_TX_DV rising edges exactly GAP_CLKS clocks apart.
//   - o_TX_DV is never high in two consecutive cycles.
//   - A byte written during WAIT never shortens the gap.
//  o_TX_Byte holds its last value when o_TX_DV=0.
// TESTING
//  Bench parameters: CLKS_PER_BIT=4, DEPTH=4, GAP_CLKS=52.
//  1 Write 8'hA5 at edge 10 into empty FIFO
//    -> o_TX_DV=1 with o_TX_Byte=8'hA5 in cycle after edge 12 only;
//       o_Empty=1 again after edge 11; o_Busy=0 after WAIT expires.
//  2 Write 8'h01,8'h02,8'h03 on 3 consecutive cycles
//    -> three o_TX_DV strobes 52 clocks apart, bytes in order 01,02,03;
//       o_Count goes 1,2,3 then decrements on each ISSUE.
//  3 Hold FSM in WAIT, write 5 bytes 8'h10..8'h14 into DEPTH=4
//    -> o_Full=1 after 4th; 5th gives o_Overflow pulse;
//       only 10..13 emerge; 8'h14 is never transmitted.
//  4 FIFO full, write 8'h77 on the ISSUE (pop) cycle
//    -> accepted; o_Count stays 4; o_Overflow stays 0;
//       8'h77 is the last byte out.
//  5 Assert i_Rst_L=0 asynchronously mid-WAIT with 3 bytes queued
//    -> outputs take reset values immediately, before the next clock edge;
//       after release no o_TX_DV until a new write.
//  6 Serial check: o_TX_DV/o_TX_Byte drive a UART transmitter; stream 8'h55,8'hAA
//    -> decoded line frames are 0x55 then 0xAA, with each start bit
//       beginning only after the previous stop bit ends.

Source files
------------

// File: rtl/uart_tx_pacer_if.sv
// Producer-side bus of the UART transmit pacer: byte write strobe in,
// FIFO status plus the paced transmitter strobe out.
interface uart_tx_pacer_if #(
    parameter int ADDR_W = 4
);
    logic              i_Wr_DV;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic              o_Busy;

    modport master (
        output i_Wr_DV,
        output i_Wr_Byte,
        input  o_Full,
        input  o_Empty,
        input  o_Count,
        input  o_Overflow,
        input  o_TX_DV,
        input  o_TX_Byte,
        input  o_Busy
    );

    modport slave (
        input  i_Wr_DV,
        input  i_Wr_Byte,
        output o_Full,
        output o_Empty,
        output o_Count,
        output o_Overflow,
        output o_TX_DV,
        output o_TX_Byte,
        output o_Busy
    );
endinterface

// File: rtl/uart_tx_pacer.sv
// Byte FIFO plus pacing FSM feeding a UART transmitter that has no ready
// output. Bytes are handed over as one-cycle o_TX_DV strobes spaced
// GAP_CLKS clocks apart so a frame always finishes before the next starts.
module uart_tx_pacer #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int GAP_CLKS     = 10 * (CLKS_PER_BIT + 1) + 2
) (
    input logic            i_Clock,
    input logic            i_Rst_L,
    uart_tx_pacer_if.slave bus
);

    localparam int                GAP_W      = $clog2(GAP_CLKS + 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(GAP_CLKS - 2);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        head_q, head_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_dv_q, tx_dv_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        mem_q [DEPTH];
    logic              pop;
    logic              push;

    // Pacing FSM: the head byte is taken on the edge that enters ISSUE, then WAIT holds off the next one.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gap_d   = GAP_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a full FIFO still accepts a write on a pop cycle because the popped slot is reused.
    always_comb begin
        push      = bus.i_Wr_DV && ((count_q != FULL_COUNT) || pop);
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        head_d    = pop ? mem_q[rd_ptr_q] : head_q;
        tx_dv_d   = (state_q == ISSUE);
        tx_byte_d = (state_q == ISSUE) ? head_q : tx_byte_q;
        ovf_d     = bus.i_Wr_DV && !push;
    end

    // Control and output registers; reset drops all queued bytes and any gap in progress.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            head_q    <= 8'h00;
            tx_byte_q <= 8'h00;
            tx_dv_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            head_q    <= head_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage array; contents are meaningless until written, so it needs no reset.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.i_Wr_Byte;
        end
    end

    assign bus.o_Full     = (count_q == FULL_COUNT);
    assign bus.o_Empty    = (count_q == '0);
    assign bus.o_Count    = count_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_TX_DV    = tx_dv_q;
    assign bus.o_TX_Byte  = tx_byte_q;
    assign bus.o_Busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_pacer.sv
// Self-checking bench for uart_tx_pacer: a constant vector table, directed
// corner-case sequences, randomized traffic against a queue-and-timestamp
// reference model, and a serial line decoder behind a simple transmitter.
module tb_uart_tx_pacer;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int GAP    = 52;

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_pacer_if #(.ADDR_W(ADDR_W)) bus();

    uart_tx_pacer #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .GAP_CLKS(GAP)
    ) dut (
        .i_Clock(clk),
        .i_Rst_L(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: byte queue, edge number of the last pop, and what that implies.
    logic [7:0] modelQ[$];
    int         edgeNo;
    int         lastPop;
    bit         popPrev;
    logic [7:0] popByte;
    bit         mDv;
    logic [7:0] mByte;
    bit         mOvf;
    bit         mBusy;

    logic [7:0] txLog[$];
    int         dvEdges[$];

    // Serial side: simple transmitter driven by the strobe, and a line decoder.
    logic       txLine = 1'b1;
    int         txBit;
    int         txClk;
    logic [9:0] txShift;
    int         overlapErr = 0;
    int         frameErr = 0;
    logic [7:0] rxByte;
    logic [7:0] rxLog[$];

    typedef struct {
        bit         wr;
        logic [7:0] data;
        int         hold;
        bit         dv;
        logic [7:0] txByte;
        int         count;
        bit         empty;
        bit         full;
        bit         busy;
        bit         ovf;
    } vec_t;

    vec_t vecs[7];
    int   rates[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        edgeNo  = 0;
        lastPop = -1000;
        popPrev = 1'b0;
        popByte = 8'h00;
        mDv     = 1'b0;
        mByte   = 8'h00;
        mOvf    = 1'b0;
        mBusy   = 1'b0;
    endtask

    // A byte leaves when one is stored and GAP edges have passed since the last one left;
    // it appears on the strobe one edge later.
    task automatic modelEdge(input bit wr, input logic [7:0] b);
        bit popNow;
        bit acc;
        int sizeBefore;
        edgeNo++;
        sizeBefore = modelQ.size();
        mDv = popPrev;
        if (popPrev) mByte = popByte;
        popNow = (sizeBefore > 0) && (edgeNo >= lastPop + GAP);
        if (popNow) begin
            popByte = modelQ.pop_front();
            lastPop = edgeNo;
        end
        acc = wr && ((sizeBefore < DEPTH) || popNow);
        if (acc) modelQ.push_back(b);
        mOvf    = wr && !acc;
        popPrev = popNow;
        mBusy   = (modelQ.size() > 0) || (edgeNo - lastPop < GAP);
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] b);
        @(negedge clk);
        bus.i_Wr_DV   = wr;
        bus.i_Wr_Byte = b;
        @(posedge clk);
        modelEdge(wr, b);
        #1;
        checkOutput("dv", bus.o_TX_DV, mDv);
        checkOutput("txByte", bus.o_TX_Byte, mByte);
        checkOutput("count", bus.o_Count, modelQ.size());
        checkOutput("empty", bus.o_Empty, modelQ.size() == 0);
        checkOutput("full", bus.o_Full, modelQ.size() == DEPTH);
        checkOutput("ovf", bus.o_Overflow, mOvf);
        checkOutput("busy", bus.o_Busy, mBusy);
        if (bus.o_TX_DV === 1'b1) begin
            txLog.push_back(bus.o_TX_Byte);
            dvEdges.push_back(edgeNo);
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, ".dv"}, bus.o_TX_DV, 0);
        checkOutput({name, ".txByte"}, bus.o_TX_Byte, 0);
        checkOutput({name, ".ovf"}, bus.o_Overflow, 0);
        checkOutput({name, ".empty"}, bus.o_Empty, 1);
        checkOutput({name, ".full"}, bus.o_Full, 0);
        checkOutput({name, ".count"}, bus.o_Count, 0);
        checkOutput({name, ".busy"}, bus.o_Busy, 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && (mBusy || modelQ.size() > 0); i++) applyStimulus(1'b0, 8'h00);
        checkOutput({name, ".drainBusy"}, bus.o_Busy, 0);
    endtask

    task automatic checkLog(input string name, input logic [7:0] exp[$]);
        checkOutput({name, ".len"}, txLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < txLog.size(); i++)
            checkOutput($sformatf("%s.byte%0d", name, i), txLog[i], exp[i]);
    endtask

    // Transmitter stand-in: 10-bit frame at CPB clocks per bit; a strobe mid-frame is an overlap.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txLine <= 1'b1;
            txBit  <= -1;
            txClk  <= 0;
        end else if (bus.o_TX_DV === 1'b1) begin
            if (txBit >= 0) overlapErr <= overlapErr + 1;
            txShift <= {1'b1, bus.o_TX_Byte, 1'b0};
            txBit   <= 0;
            txClk   <= 0;
            txLine  <= 1'b0;
        end else if (txBit >= 0) begin
            if (txClk == CPB - 1) begin
                txClk <= 0;
                if (txBit == 9) begin
                    txBit  <= -1;
                    txLine <= 1'b1;
                end else begin
                    txBit  <= txBit + 1;
                    txLine <= txShift[txBit + 1];
                end
            end else begin
                txClk <= txClk + 1;
            end
        end
    end

    // Line decoder: find the start edge, then sample each bit near its middle.
    always begin
        @(negedge txLine);
        repeat (2) @(negedge clk);
        if (txLine !== 1'b0) frameErr++;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rxByte[i] = txLine;
        end
        repeat (CPB) @(negedge clk);
        if (txLine !== 1'b1) frameErr++;
        rxLog.push_back(rxByte);
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp[$];

        vecs[0] = '{1'b1, 8'hA5, 1,  1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1,  1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1,  1'b1, 8'hA5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1,  1'b0, 8'hA5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 48, 1'b0, 8'hA5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1,  1'b0, 8'hA5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1,  1'b0, 8'hA5, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        rates   = '{3, 10, 40, 2, 60, 5};

        rst_n         = 1'b0;
        bus.i_Wr_DV   = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        checkReset("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) applyStimulus(1'b0, 8'h00);

        // Single byte into an empty FIFO: latency, empty timing and gap expiry.
        for (int i = 0; i < 7; i++) begin
            for (int h = 0; h < vecs[i].hold; h++) applyStimulus(vecs[i].wr, vecs[i].data);
            checkOutput($sformatf("vec%0d.dv", i), bus.o_TX_DV, vecs[i].dv);
            checkOutput($sformatf("vec%0d.txByte", i), bus.o_TX_Byte, vecs[i].txByte);
            checkOutput($sformatf("vec%0d.count", i), bus.o_Count, vecs[i].count);
            checkOutput($sformatf("vec%0d.empty", i), bus.o_Empty, vecs[i].empty);
            checkOutput($sformatf("vec%0d.full", i), bus.o_Full, vecs[i].full);
            checkOutput($sformatf("vec%0d.busy", i), bus.o_Busy, vecs[i].busy);
            checkOutput($sformatf("vec%0d.ovf", i), bus.o_Overflow, vecs[i].ovf);
        end

        // Three bytes queued while a gap runs: count climbs, strobes exactly GAP apart.
        txLog.delete();
        dvEdges.delete();
        applyStimulus(1'b1, 8'hEE);
        repeat (5) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h01);
        checkOutput("burst.count1", bus.o_Count, 1);
        applyStimulus(1'b1, 8'h02);
        checkOutput("burst.count2", bus.o_Count, 2);
        applyStimulus(1'b1, 8'h03);
        checkOutput("burst.count3", bus.o_Count, 3);
        applyStimulus(1'b0, 8'h00);
        drain("burst");
        exp = '{8'hEE, 8'h01, 8'h02, 8'h03};
        checkLog("burst", exp);
        for (int i = 1; i < dvEdges.size(); i++)
            checkOutput($sformatf("burst.gap%0d", i), dvEdges[i] - dvEdges[i-1], GAP);

        // Overfill during a gap: fifth byte is rejected with a one-cycle pulse.
        txLog.delete();
        applyStimulus(1'b1, 8'hC0);
        repeat (3) applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h10 + 8'(i));
        checkOutput("ovfl.full", bus.o_Full, 1);
        checkOutput("ovfl.ovfBefore", bus.o_Overflow, 0);
        applyStimulus(1'b1, 8'h14);
        checkOutput("ovfl.ovfPulse", bus.o_Overflow, 1);
        checkOutput("ovfl.count", bus.o_Count, 4);
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovfl.ovfClear", bus.o_Overflow, 0);
        drain("ovfl");
        exp = '{8'hC0, 8'h10, 8'h11, 8'h12, 8'h13};
        checkLog("ovfl", exp);

        // Write into a full FIFO exactly on the pop edge is accepted.
        txLog.delete();
        applyStimulus(1'b1, 8'hC1);
        repeat (3) applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h20 + 8'(i));
        applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < GAP && (edgeNo + 1 < lastPop + GAP); i++) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h77);
        checkOutput("popPush.count", bus.o_Count, 4);
        checkOutput("popPush.ovf", bus.o_Overflow, 0);
        checkOutput("popPush.full", bus.o_Full, 1);
        applyStimulus(1'b0, 8'h00);
        drain("popPush");
        exp = '{8'hC1, 8'h20, 8'h21, 8'h22, 8'h23, 8'h77};
        checkLog("popPush", exp);

        // Asynchronous reset mid-gap with bytes queued.
        applyStimulus(1'b1, 8'hC2);
        repeat (3) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h30);
        applyStimulus(1'b1, 8'h31);
        applyStimulus(1'b1, 8'h32);
        repeat (5) applyStimulus(1'b0, 8'h00);
        checkOutput("areset.preCount", bus.o_Count, 3);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("areset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        dvEdges.delete();
        repeat (100) applyStimulus(1'b0, 8'h00);
        checkOutput("areset.noDv", dvEdges.size(), 0);

        // Serial frames through the transmitter stand-in.
        rxLog.delete();
        frameErr = 0;
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b1, 8'hAA);
        applyStimulus(1'b0, 8'h00);
        drain("serial");
        repeat (10) applyStimulus(1'b0, 8'h00);
        checkOutput("serial.frames", rxLog.size(), 2);
        if (rxLog.size() >= 2) begin
            checkOutput("serial.rx0", rxLog[0], 8'h55);
            checkOutput("serial.rx1", rxLog[1], 8'hAA);
        end
        checkOutput("serial.frameErr", frameErr, 0);

        // Randomized traffic at several write densities.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 99) < rates[seg]) applyStimulus(1'b1, 8'($urandom));
                else applyStimulus(1'b0, 8'h00);
            end
        end
        applyStimulus(1'b0, 8'h00);
        drain("random");
        checkOutput("overlap", overlapErr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
